// File: rtl/mtimer_if.sv
// mtimer_if: control inputs and BCD time outputs between the stopwatch FSM side and the timer datapath
interface mtimer_if;
  logic [1:0] state;
  logic       clr;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic       step;
  logic       wrap;
  logic       running;
  modport master (output state, clr, input sec_ones, sec_tens, min_ones, min_tens, step, wrap, running);
  modport slave (input state, clr, output sec_ones, sec_tens, min_ones, min_tens, step, wrap, running);
endinterface

// File: rtl/mtimer_counter.sv
// mtimer_counter: BCD mm:ss stopwatch datapath, 1 Hz in START, manual/auto-repeat stepping in INC
module mtimer_counter #(
  parameter int TICK_DIV   = 50000000,
  parameter int INC_REPEAT = 12500000
) (
  input logic     clk,
  input logic     reset,
  mtimer_if.slave bus
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int RW = $clog2(INC_REPEAT);
  logic [PW-1:0] pre;
  logic [RW-1:0] rep;
  logic [1:0] prev_state;
  logic is_start, is_inc, is_stop, inc_entry, pre_hit, rep_hit, adv;
  logic c0, c1, c2, c3;
  logic [3:0] so_n, st_n, mo_n, mt_n;
  always_comb begin
    is_start  = bus.state == 2'b01;
    is_inc    = bus.state == 2'b10;
    is_stop   = !is_start && !is_inc;
    inc_entry = is_inc && prev_state != 2'b10;
    pre_hit   = is_start && pre == PW'(TICK_DIV - 1);
    rep_hit   = is_inc && !inc_entry && rep == RW'(INC_REPEAT - 1);
    adv       = pre_hit || inc_entry || rep_hit;
    c0 = bus.sec_ones == 4'd9;
    c1 = c0 && bus.sec_tens == 4'd5;
    c2 = c1 && bus.min_ones == 4'd9;
    c3 = c2 && bus.min_tens == 4'd5;
    so_n = c0 ? 4'd0 : bus.sec_ones + 4'd1;
    st_n = c0 ? (c1 ? 4'd0 : bus.sec_tens + 4'd1) : bus.sec_tens;
    mo_n = c1 ? (c2 ? 4'd0 : bus.min_ones + 4'd1) : bus.min_ones;
    mt_n = c2 ? (c3 ? 4'd0 : bus.min_tens + 4'd1) : bus.min_tens;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pre          <= '0;
      rep          <= '0;
      prev_state   <= 2'b00;
      bus.sec_ones <= '0;
      bus.sec_tens <= '0;
      bus.min_ones <= '0;
      bus.min_tens <= '0;
      bus.step     <= 1'b0;
      bus.wrap     <= 1'b0;
      bus.running  <= 1'b0;
    end else begin
      prev_state  <= bus.state;
      bus.running <= is_start;
      bus.step    <= adv;
      bus.wrap    <= adv && c3;
      // prescaler only moves in START; it holds its fraction elsewhere unless cleared
      pre <= is_start ? (pre_hit ? '0 : pre + 1'b1) : (is_stop && bus.clr) ? '0 : pre;
      rep <= (is_inc && !inc_entry && !rep_hit) ? rep + 1'b1 : '0;
      if (is_stop && bus.clr) begin
        bus.sec_ones <= '0;
        bus.sec_tens <= '0;
        bus.min_ones <= '0;
        bus.min_tens <= '0;
      end else if (adv) begin
        bus.sec_ones <= so_n;
        bus.sec_tens <= st_n;
        bus.min_ones <= mo_n;
        bus.min_tens <= mt_n;
      end
    end
  end
endmodule

// File: tb/tb_mtimer_counter.sv
// tb_mtimer_counter: directed stimulus with a step scoreboard checked by an independent monitor
module tb_mtimer_counter;
  logic clk = 1'b0;
  logic reset;
  int compared = 0;
  int mismatched = 0;
  int secs = 0;
  logic [16:0] exp_q[$];
  mtimer_if bus ();
  mtimer_counter #(.TICK_DIV(4), .INC_REPEAT(3)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [16:0] pack(int s, logic w);
    int m = s / 60;
    int x = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10), w};
  endfunction
  function automatic logic [15:0] cur();
    return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
  endfunction
  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic push_steps(int k);
    for (int i = 0; i < k; i++) begin
      secs = (secs + 1) % 3600;
      exp_q.push_back(pack(secs, secs == 0));
    end
  endtask
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // monitor: every step pulse must match the oldest queued expectation
  always @(negedge clk) begin
    logic [16:0] e;
    if (bus.step) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL spurious_step: got %h expected no step", {cur(), bus.wrap});
      end else begin
        e = exp_q.pop_front();
        if ({cur(), bus.wrap} !== e) begin
          mismatched++;
          $display("FAIL step_value: got %h expected %h", {cur(), bus.wrap}, e);
        end
      end
    end else if (bus.wrap) begin
      compared++;
      mismatched++;
      $display("FAIL wrap_without_step: got wrap=1 expected 0");
    end
  end
  initial begin
    reset = 1'b1;
    bus.state = 2'b00;
    bus.clr = 1'b0;
    tick(2);
    chk("reset_time", 32'(cur()), 32'h0);
    chk("reset_flags", {29'd0, bus.step, bus.wrap, bus.running}, 32'h0);
    reset = 1'b0;
    bus.state = 2'b01;
    push_steps(3);
    tick(12);
    chk("t1_time", 32'(cur()), 32'h0003);
    chk("t1_running", 32'(bus.running), 32'h1);
    bus.state = 2'b00;
    tick(1);
    chk("t1_stop_running", 32'(bus.running), 32'h0);
    bus.state = 2'b10;
    push_steps(56);
    tick(166);
    bus.state = 2'b00;
    tick(1);
    chk("t2_preload", 32'(cur()), 32'h0059);
    bus.state = 2'b01;
    push_steps(1);
    tick(4);
    bus.state = 2'b00;
    tick(1);
    chk("t2_carry", 32'(cur()), 32'h0100);
    bus.state = 2'b10;
    push_steps(3539);
    tick(3 * 3538 + 1);
    bus.state = 2'b00;
    tick(1);
    chk("t3_preload", 32'(cur()), 32'h5959);
    bus.state = 2'b01;
    push_steps(1);
    tick(4);
    bus.state = 2'b00;
    tick(1);
    chk("t3_wrapped", 32'(cur()), 32'h0000);
    chk("t3_pulse_one_cycle", {30'd0, bus.step, bus.wrap}, 32'h0);
    bus.state = 2'b01;
    push_steps(1);
    tick(2);
    bus.state = 2'b00;
    tick(5);
    chk("t4_frozen", 32'(cur()), 32'h0000);
    bus.state = 2'b01;
    tick(2);
    bus.state = 2'b00;
    tick(1);
    chk("t4_resumed", 32'(cur()), 32'h0001);
    bus.clr = 1'b1;
    tick(1);
    bus.clr = 1'b0;
    secs = 0;
    chk("t5_clr", {cur(), 15'd0, bus.step}, 32'h0);
    bus.state = 2'b10;
    push_steps(3);
    tick(7);
    bus.state = 2'b00;
    tick(1);
    chk("t5_inc_held", 32'(cur()), 32'h0003);
    bus.state = 2'b10;
    push_steps(1);
    tick(1);
    bus.state = 2'b00;
    tick(1);
    chk("t5_reentry", 32'(cur()), 32'h0004);
    bus.state = 2'b10;
    push_steps(750);
    tick(2248);
    bus.state = 2'b00;
    tick(1);
    chk("t6_preload", 32'(cur()), 32'h1234);
    bus.clr = 1'b1;
    tick(1);
    bus.clr = 1'b0;
    secs = 0;
    chk("t6_clr", {cur(), 14'd0, bus.step, bus.wrap}, 32'h0);
    bus.state = 2'b01;
    push_steps(5);
    tick(20);
    bus.clr = 1'b1;
    tick(1);
    bus.clr = 1'b0;
    chk("t6_clr_ignored", 32'(cur()), 32'h0005);
    chk("t6_running", 32'(bus.running), 32'h1);
    bus.state = 2'b10;
    push_steps(1);
    tick(1);
    reset = 1'b1;
    tick(1);
    chk("t6_reset_time", 32'(cur()), 32'h0);
    chk("t6_reset_flags", {29'd0, bus.step, bus.wrap, bus.running}, 32'h0);
    reset = 1'b0;
    bus.state = 2'b00;
    tick(3);
    chk("queue_drained", exp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
